pipe_latch_skid: RTL and testbench
==================================

Name: pipe_latch_skid

Overview:
- Parametrised, elastic pipeline-stage register that replaces the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block.
- Carries an arbitrary packed control+data bundle between stages using a valid/ready handshake.
- Adds an optional one-entry skid buffer, synchronous flush, and sticky halt capture.
- Each stage wrapper in the datapath instantiates one copy and packs its stage signals into the data word.

Parameters:
- DATA_W, 128, width of the packed stage bundle in bits (1 to 1024).
- SKID, 1, 1 = two-entry elastic buffer with registered in_ready; 0 = single register with combinational ready.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream stage presents a bundle.
- in_ready  output  1  block will accept a bundle this cycle.
- in_data  input  DATA_W  upstream bundle.
- in_halt  input  1  bundle carries a halt instruction.
- flush  input  1  synchronous squash of all held bundles.
- out_valid  output  1  held bundle is presented downstream.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_W  bundle presented downstream.
- out_halt  output  1  halt flag of the presented bundle.
- occupancy  output  2  number of held bundles (0..2).
- halted  output  1  sticky; a halt bundle has been delivered downstream.

Behaviour:
- Reset (nRST low, asynchronous): out_valid=0, out_data=0, out_halt=0, occupancy=0, halted=0, skid entry invalid.
  - in_ready=1 with SKID=1; with SKID=0 it follows the combinational rule below.
- Transfer definitions: accept = in_valid & in_ready; deliver = out_valid & out_ready.
- Latency is one cycle: an accepted bundle appears on out_data/out_valid the next cycle when the main register is empty or is delivering that cycle.
- SKID=1:
  - in_ready = !skid_valid & !halted, driven from registers only.
  - If accept occurs while main is full and not delivering, the bundle goes to skid.
  - On a deliver with skid full, skid moves to main the same edge.
  - Order is strictly FIFO.
- SKID=0:
  - in_ready = (!out_valid | out_ready) & !halted.
  - No skid storage exists; occupancy is never 2.
- Holding: out_data and out_halt are stable while out_valid=1 and out_ready=0.
- Flush:
  - At the next edge, main and skid valid bits clear and occupancy becomes 0.
  - An accept in the flush cycle is discarded.
  - A deliver in the flush cycle still counts (downstream consumed it), including halt capture.
  - Data registers are not cleared by flush; only the valid bits are.
- Halt:
  - halted sets at the edge following a deliver with out_halt=1.
  - Once set, in_ready=0 and no further accepts occur.
  - Bundles already held still drain normally.
  - Only nRST clears halted; flush does not.
- Simultaneous accept and deliver with occupancy 1: main is replaced by the new bundle and occupancy stays 1; skid is unused.
- occupancy updates as +1 on accept-only, -1 on deliver-only, unchanged on both, and 0 after flush.
- Reset asserted mid-transfer wins over every other event; no partial state survives.

Test Plan:
- Streaming: SKID=1, out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, in_ready stays 1, occupancy=1 throughout.
- Backpressure: SKID=1, hold out_ready=0 and push 0xA then 0xB -> occupancy=2, in_ready=0. Release out_ready -> 0xA then 0xB delivered in order, in_ready returns to 1 the cycle after 0xA leaves.
- SKID=0 backpressure: hold out_ready=0 with out_valid=1 -> in_ready=0 combinationally. Raise out_ready and in_valid together -> a new bundle is accepted the same cycle with no bubble.
- Flush: occupancy=2 (0x5, 0x6), assert flush for one cycle with in_valid=1 and data 0x7 -> next cycle out_valid=0, occupancy=0, and 0x7 never appears.
- Halt: deliver a bundle with in_halt=1, followed by 0x9 pending -> halted=1 the next cycle, in_ready=0, 0x9 never accepted. Flush -> halted remains 1.
- Async reset: assert nRST low between edges while occupancy=2 -> outputs immediately reset to the listed values. Release -> normal accept on the next edge.

Source files
------------

// File: rtl/pipe_latch_skid.sv
// Elastic valid/ready pipeline-stage register with an optional one-entry skid
// buffer, synchronous flush of held bundles and sticky halt capture.
module pipe_latch_skid #(
  parameter int DATA_W = 128,
  parameter int SKID   = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  output logic [1:0]        occupancy,
  output logic              halted
);

  logic              main_vld_q, main_vld_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              main_halt_q, main_halt_d;
  logic              skid_vld_q;
  logic [DATA_W-1:0] skid_data_q;
  logic              skid_halt_q;
  logic              halted_q, halted_d;
  logic              accept, deliver;

  assign accept  = in_valid & in_ready;
  assign deliver = main_vld_q & out_ready;

  // Main register: refilled from skid first so ordering stays FIFO.
  always_comb begin
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    main_halt_d = main_halt_q;
    if (deliver) begin
      if (skid_vld_q) begin
        main_vld_d  = 1'b1;
        main_data_d = skid_data_q;
        main_halt_d = skid_halt_q;
      end else if (accept) begin
        main_vld_d  = 1'b1;
        main_data_d = in_data;
        main_halt_d = in_halt;
      end else begin
        main_vld_d  = 1'b0;
      end
    end else if (accept && !main_vld_q) begin
      main_vld_d  = 1'b1;
      main_data_d = in_data;
      main_halt_d = in_halt;
    end
    if (flush) begin
      main_vld_d  = 1'b0;
      main_data_d = main_data_q;
      main_halt_d = main_halt_q;
    end
  end

  // A consumed halt bundle still counts when it leaves during a flush.
  assign halted_d = halted_q | (deliver & main_halt_q);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      main_vld_q  <= 1'b0;
      main_data_q <= '0;
      main_halt_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_data_q <= main_data_d;
      main_halt_q <= main_halt_d;
      halted_q    <= halted_d;
    end
  end

  if (SKID != 0) begin : g_skid
    logic              skid_vld_d;
    logic [DATA_W-1:0] skid_data_d;
    logic              skid_halt_d;

    always_comb begin
      skid_vld_d  = skid_vld_q;
      skid_data_d = skid_data_q;
      skid_halt_d = skid_halt_q;
      if (deliver) begin
        skid_vld_d  = 1'b0;
      end else if (accept && main_vld_q) begin
        skid_vld_d  = 1'b1;
        skid_data_d = in_data;
        skid_halt_d = in_halt;
      end
      if (flush) begin
        skid_vld_d  = 1'b0;
        skid_data_d = skid_data_q;
        skid_halt_d = skid_halt_q;
      end
    end

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        skid_vld_q  <= 1'b0;
        skid_data_q <= '0;
        skid_halt_q <= 1'b0;
      end else begin
        skid_vld_q  <= skid_vld_d;
        skid_data_q <= skid_data_d;
        skid_halt_q <= skid_halt_d;
      end
    end

    // Ready comes from flops only, breaking the upstream combinational path.
    assign in_ready = ~skid_vld_q & ~halted_q;
  end else begin : g_noskid
    assign skid_vld_q  = 1'b0;
    assign skid_data_q = '0;
    assign skid_halt_q = 1'b0;
    assign in_ready    = (~main_vld_q | out_ready) & ~halted_q;
  end

  assign out_valid = main_vld_q;
  assign out_data  = main_data_q;
  assign out_halt  = main_halt_q;
  assign occupancy = 2'(main_vld_q) + 2'(skid_vld_q);
  assign halted    = halted_q;

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Bench for pipe_latch_skid: instance 1 uses the skid buffer, instance 0 does not.
module tb_pipe_latch_skid;

  logic       CLK;
  logic       nRST;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] in_data   [2];
  logic       in_halt   [2];
  logic       flush     [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] out_data  [2];
  logic       out_halt  [2];
  logic [1:0] occupancy [2];
  logic       halted    [2];

  int n_chk  = 0;
  int n_pass = 0;

  pipe_latch_skid #(.DATA_W(8), .SKID(1)) u_skid (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_halt(in_halt[1]), .flush(flush[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_halt(out_halt[1]), .occupancy(occupancy[1]), .halted(halted[1])
  );

  pipe_latch_skid #(.DATA_W(8), .SKID(0)) u_noskid (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_halt(in_halt[0]), .flush(flush[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_halt(out_halt[0]), .occupancy(occupancy[0]), .halted(halted[0])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: a FIFO of up to two {halt,data} entries plus a halted flag.
  logic [8:0] mbuf [2][2];
  int         mcnt [2];
  bit         mhalt[2];

  typedef struct {
    bit         iv;
    logic [7:0] d;
    bit         fl;
    bit         orr;
    bit         exp_ir;
    bit         exp_ov;
    logic [7:0] exp_od;
    logic [1:0] exp_occ;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input int k, input bit iv, input logic [7:0] d, input bit h,
                       input bit fl, input bit orr);
    in_valid[k]  = iv;
    in_data[k]   = d;
    in_halt[k]   = h;
    flush[k]     = fl;
    out_ready[k] = orr;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit model_ready(input int k);
    if (mhalt[k]) return 1'b0;
    if (k == 1) return mcnt[k] < 2;
    return (mcnt[k] == 0) || out_ready[k];
  endfunction

  task automatic model_step(input int k);
    bit acc, del;
    acc = in_valid[k] && model_ready(k);
    del = (mcnt[k] > 0) && out_ready[k];
    if (del) begin
      if (mbuf[k][0][8]) mhalt[k] = 1'b1;
      mbuf[k][0] = mbuf[k][1];
      mcnt[k]--;
    end
    if (flush[k]) mcnt[k] = 0;
    else if (acc) begin
      mbuf[k][mcnt[k]] = {in_halt[k], in_data[k]};
      mcnt[k]++;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k]  = 0;
      mhalt[k] = 1'b0;
    end
  endtask

  task automatic chk_state(input int k);
    logic [12:0] act, exp;
    bit ov;
    ov  = mcnt[k] > 0;
    exp = {ov, 2'(mcnt[k]), mhalt[k], ov ? mbuf[k][0] : 9'h0};
    act = {out_valid[k], occupancy[k], halted[k],
           out_valid[k] ? {out_halt[k], out_data[k]} : 9'h0};
    chk($sformatf("rand_state%0d", k), 32'(act), 32'(exp));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 2'd1};
    tbl[1]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 8'h02, 2'd1};
    tbl[2]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 2'd1};
    tbl[3]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 8'h04, 2'd1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[5]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0A, 2'd1};
    tbl[6]  = '{1'b1, 8'h0B, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0A, 2'd2};
    tbl[7]  = '{1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0A, 2'd2};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0B, 2'd1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0B, 2'd1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[11] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 2'd1};
    tbl[12] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[14] = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 2'd1};
    tbl[15] = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 2'd2};
    tbl[16] = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
    tbl[17] = '{1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 1'b1, 8'h08, 2'd1};
    tbl[18] = '{1'b1, 8'h09, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};

    nRST = 1'b0;
    drive(0, 0, 8'h00, 0, 0, 0);
    drive(1, 0, 8'h00, 0, 0, 0);
    #12;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_ov%0d", k),   32'(out_valid[k]), 32'd0);
      chk($sformatf("reset_od%0d", k),   32'(out_data[k]),  32'd0);
      chk($sformatf("reset_occ%0d", k),  32'(occupancy[k]), 32'd0);
      chk($sformatf("reset_halt%0d", k), 32'(halted[k]),    32'd0);
    end
    chk("reset_ir1", 32'(in_ready[1]), 32'd1);
    nRST = 1'b1;
    tick();

    for (int i = 0; i < 20; i++) begin
      drive(1, tbl[i].iv, tbl[i].d, 0, tbl[i].fl, tbl[i].orr);
      #1;
      chk($sformatf("tbl%0d_ir", i), 32'(in_ready[1]), 32'(tbl[i].exp_ir));
      tick();
      chk($sformatf("tbl%0d_ov", i),  32'(out_valid[1]), 32'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d_occ", i), 32'(occupancy[1]), 32'(tbl[i].exp_occ));
      if (tbl[i].exp_ov)
        chk($sformatf("tbl%0d_od", i), 32'(out_data[1]), 32'(tbl[i].exp_od));
    end

    drive(1, 1, 8'h41, 0, 0, 0); tick();
    drive(1, 1, 8'h42, 0, 0, 0); tick();
    chk("areset_pre_occ", 32'(occupancy[1]), 32'd2);
    #2 nRST = 1'b0;
    #1;
    chk("areset_ov",   32'(out_valid[1]), 32'd0);
    chk("areset_od",   32'(out_data[1]),  32'd0);
    chk("areset_occ",  32'(occupancy[1]), 32'd0);
    chk("areset_ir",   32'(in_ready[1]),  32'd1);
    nRST = 1'b1;
    drive(1, 1, 8'h43, 0, 0, 0); tick();
    chk("areset_post", 32'({out_valid[1], occupancy[1], out_data[1]}), 32'({1'b1, 2'd1, 8'h43}));
    drive(1, 0, 8'h00, 0, 0, 1); tick();

    drive(1, 1, 8'h03, 1, 0, 0); tick();
    chk("halt_held", 32'({out_halt[1], occupancy[1]}), 32'({1'b1, 2'd1}));
    drive(1, 0, 8'h00, 0, 0, 1); tick();
    chk("halt_set",  32'({halted[1], out_valid[1]}), 32'({1'b1, 1'b0}));
    drive(1, 1, 8'h09, 0, 0, 1); #1;
    chk("halt_ir", 32'(in_ready[1]), 32'd0);
    tick();
    chk("halt_no_accept", 32'({out_valid[1], occupancy[1]}), 32'd0);
    drive(1, 0, 8'h00, 0, 1, 1); tick();
    chk("halt_after_flush", 32'(halted[1]), 32'd1);
    drive(1, 0, 8'h00, 0, 0, 0);
    nRST = 1'b0; #1 nRST = 1'b1;

    drive(0, 1, 8'h31, 0, 0, 0); #1;
    chk("ns_ir_empty", 32'(in_ready[0]), 32'd1);
    tick();
    chk("ns_first", 32'({out_valid[0], out_data[0]}), 32'({1'b1, 8'h31}));
    drive(0, 0, 8'h00, 0, 0, 0); #1;
    chk("ns_ir_bp", 32'(in_ready[0]), 32'd0);
    drive(0, 1, 8'h32, 0, 0, 1); #1;
    chk("ns_ir_release", 32'(in_ready[0]), 32'd1);
    tick();
    chk("ns_nobubble", 32'({out_valid[0], occupancy[0], out_data[0]}), 32'({1'b1, 2'd1, 8'h32}));
    drive(0, 0, 8'h00, 0, 0, 1); tick();

    nRST = 1'b0; #1 nRST = 1'b1;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 49) begin
        nRST = 1'b0; #1 nRST = 1'b1;
        model_reset();
      end
      for (int k = 0; k < 2; k++)
        drive(k, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0,
              $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rand_ir%0d", k), 32'(in_ready[k]), 32'(model_ready(k)));
        model_step(k);
      end
      tick();
      for (int k = 0; k < 2; k++) chk_state(k);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
